ipc_mailbox: RTL and testbench



---
 rtl/ipc_mailbox_pkg.sv | 41 ++++
 rtl/mbox_fifo.sv | 60 ++++++
 rtl/ipc_mailbox.sv | 146 ++++++++++++++
 tb/tb_ipc_mailbox.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ipc_mailbox_pkg.sv
// Shared constants for the HPS <-> Nios mailbox: register offsets, STATUS and
// IRQ_PEND bit positions, and the STATUS word packing helper.
package ipc_mailbox_pkg;

  localparam int DATA_W = 32;

  // Word offsets within each port's register window
  localparam logic [1:0] REG_DATA     = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_IRQ_EN   = 2'd2;
  localparam logic [1:0] REG_IRQ_PEND = 2'd3;

  // STATUS bit positions ([7:0] is rx_count)
  localparam int STAT_RX_EMPTY  = 8;
  localparam int STAT_TX_FULL   = 9;
  localparam int STAT_OVERFLOW  = 10;
  localparam int STAT_UNDERFLOW = 11;

  // IRQ_EN / IRQ_PEND bit positions
  localparam int PEND_RX_ARRIVED = 0;
  localparam int PEND_TX_SPACE   = 1;

  // Assemble a STATUS word; unused upper bits read as zero
  function automatic logic [DATA_W-1:0] pack_status(
    input logic [7:0] rx_count,
    input logic       rx_empty,
    input logic       tx_full,
    input logic       overflow,
    input logic       underflow
  );
    logic [DATA_W-1:0] s;
    s                 = '0;
    s[7:0]            = rx_count;
    s[STAT_RX_EMPTY]  = rx_empty;
    s[STAT_TX_FULL]   = tx_full;
    s[STAT_OVERFLOW]  = overflow;
    s[STAT_UNDERFLOW] = underflow;
    return s;
  endfunction

endpackage

// File: rtl/mbox_fifo.sv
// Single-direction message FIFO with show-ahead head word. A push into a full
// FIFO is still accepted when a pop commits in the same cycle; a pop from an
// empty FIFO is refused (the caller flags underflow).
module mbox_fifo
  import ipc_mailbox_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       push_ok,
  output logic                       pop_ok
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rd_ptr];

  // Storage write; entries are only ever read behind a valid count
  // NOTE: the data array has no reset on purpose -- it lets it map to RAM,
  // and stale contents are never visible because count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n)
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ipc_mailbox.sv
// Bidirectional HPS (port A) <-> Nios (port B) mailbox. Two FIFOs cross the
// ports (A2B, B2A); each port has an identical register/decode slice with
// sticky error flags, interrupt enable/pending and a 1-cycle read pipeline.
module ipc_mailbox
  import ipc_mailbox_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        a_address,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [DATA_W-1:0] a_writedata,
  output logic [DATA_W-1:0] a_readdata,
  output logic              a_irq,
  input  logic [1:0]        b_address,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [DATA_W-1:0] b_writedata,
  output logic [DATA_W-1:0] b_readdata,
  output logic              b_irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Port-indexed views: index 0 = A, 1 = B. FIFO index f is pushed by port f.
  logic [1:0]        addr   [2];
  logic [DATA_W-1:0] wdata  [2];
  logic [1:0]        rd;
  logic [1:0]        wr;
  logic [1:0]        data_wr;
  logic [1:0]        data_rd;

  logic [DATA_W-1:0] f_head  [2];
  logic [CW-1:0]     f_count [2];
  logic [1:0]        f_empty;
  logic [1:0]        f_full;
  logic [1:0]        f_push_ok;
  logic [1:0]        f_pop_ok;

  logic [DATA_W-1:0] port_rdata [2];
  logic [1:0]        port_irq;

  assign addr[0]  = a_address;
  assign addr[1]  = b_address;
  assign wdata[0] = a_writedata;
  assign wdata[1] = b_writedata;
  assign rd       = {b_read, a_read};
  assign wr       = {b_write, a_write};

  assign a_readdata = port_rdata[0];
  assign b_readdata = port_rdata[1];
  assign a_irq      = port_irq[0];
  assign b_irq      = port_irq[1];

  mbox_fifo #(.DEPTH(DEPTH)) u_fifo_a2b (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (data_wr[0]),
    .push_data (wdata[0]),
    .pop       (data_rd[1]),
    .head      (f_head[0]),
    .count     (f_count[0]),
    .empty     (f_empty[0]),
    .full      (f_full[0]),
    .push_ok   (f_push_ok[0]),
    .pop_ok    (f_pop_ok[0])
  );

  mbox_fifo #(.DEPTH(DEPTH)) u_fifo_b2a (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (data_wr[1]),
    .push_data (wdata[1]),
    .pop       (data_rd[0]),
    .head      (f_head[1]),
    .count     (f_count[1]),
    .empty     (f_empty[1]),
    .full      (f_full[1]),
    .push_ok   (f_push_ok[1]),
    .pop_ok    (f_pop_ok[1])
  );

  for (genvar p = 0; p < 2; p++) begin : g_port
    // This port transmits into FIFO p and receives from FIFO 1-p.
    localparam int RX = 1 - p;

    logic [1:0]        irq_en;
    logic [1:0]        irq_pend;
    logic              overflow;
    logic              underflow;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] rd_mux;
    logic              status_wr;
    logic [1:0]        pend_set;
    logic [1:0]        pend_clr;

    assign data_wr[p] = wr[p] && (addr[p] == REG_DATA);
    assign data_rd[p] = rd[p] && (addr[p] == REG_DATA);
    assign status_wr  = wr[p] && (addr[p] == REG_STATUS);

    // Event sources: arrival into our RX FIFO; our TX FIFO leaving full
    assign pend_set[PEND_RX_ARRIVED] = f_push_ok[RX];
    assign pend_set[PEND_TX_SPACE]   = f_full[p] & f_pop_ok[p] & ~f_push_ok[p];
    assign pend_clr = (wr[p] && (addr[p] == REG_IRQ_PEND)) ? wdata[p][1:0] : 2'b00;

    // Read-data selection for the addressed register
    // NOTE: assigning a default first keeps every path covered, so no latch
    // is inferred even if a case arm is later removed.
    always_comb begin
      rd_mux = '0;
      case (addr[p])
        REG_DATA:     rd_mux = f_empty[RX] ? '0 : f_head[RX];
        REG_STATUS:   rd_mux = pack_status(8'(f_count[RX]), f_empty[RX],
                                           f_full[p], overflow, underflow);
        REG_IRQ_EN:   rd_mux = {30'b0, irq_en};
        REG_IRQ_PEND: rd_mux = {30'b0, irq_pend};
        default:      rd_mux = '0;
      endcase
    end

    // Control/status registers and registered read data; set beats W1C clear
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        irq_en    <= '0;
        irq_pend  <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
        rdata     <= '0;
      end else begin
        if (wr[p] && (addr[p] == REG_IRQ_EN)) irq_en <= wdata[p][1:0];
        irq_pend  <= pend_set | (irq_pend & ~pend_clr);
        overflow  <= (data_wr[p] & ~f_push_ok[p]) |
                     (overflow & ~(status_wr & wdata[p][STAT_OVERFLOW]));
        underflow <= (data_rd[p] & ~f_pop_ok[RX]) |
                     (underflow & ~(status_wr & wdata[p][STAT_UNDERFLOW]));
        if (rd[p]) rdata <= rd_mux;
      end
    end

    assign port_rdata[p] = rdata;
    assign port_irq[p]   = |(irq_pend & irq_en);
  end

endmodule

// File: tb/tb_ipc_mailbox.sv
// Directed self-checking bench for ipc_mailbox (DEPTH = 16). Inputs change on
// the falling edge; outputs are sampled on the falling edge after the bus edge.
module tb_ipc_mailbox;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  a_address, b_address;
  logic        a_read, a_write, b_read, b_write;
  logic [31:0] a_writedata, b_writedata;
  logic [31:0] a_readdata, b_readdata;
  logic        a_irq, b_irq;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q [$];
  logic [31:0] rdv;

  localparam logic [1:0] DATA = 2'd0, STATUS = 2'd1, IEN = 2'd2, IPEND = 2'd3;

  always #5 clk = ~clk;

  ipc_mailbox #(.DEPTH(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .a_address   (a_address),
    .a_read      (a_read),
    .a_write     (a_write),
    .a_writedata (a_writedata),
    .a_readdata  (a_readdata),
    .a_irq       (a_irq),
    .b_address   (b_address),
    .b_read      (b_read),
    .b_write     (b_write),
    .b_writedata (b_writedata),
    .b_readdata  (b_readdata),
    .b_irq       (b_irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit port, input bit w, input bit r,
                       input logic [1:0] ad, input logic [31:0] d);
    if (port == 1'b0) begin
      a_write = w; a_read = r; a_address = ad; a_writedata = d;
    end else begin
      b_write = w; b_read = r; b_address = ad; b_writedata = d;
    end
  endtask

  task automatic idle_all();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  // Called at a falling edge; returns at the falling edge after the bus edge
  task automatic wr_reg(input bit port, input logic [1:0] ad, input logic [31:0] d);
    drive(port, 1'b1, 1'b0, ad, d);
    @(negedge clk);
    idle_all();
  endtask

  task automatic rd_reg(input bit port, input logic [1:0] ad, output logic [31:0] d);
    drive(port, 1'b0, 1'b1, ad, 32'h0);
    @(negedge clk);
    idle_all();
    d = (port == 1'b0) ? a_readdata : b_readdata;
  endtask

  task automatic expect_reg(input bit port, input logic [1:0] ad,
                            input logic [31:0] exp, input string tag);
    logic [31:0] v;
    rd_reg(port, ad, v);
    check(tag, v, exp);
  endtask

  initial begin
    reset_n = 1'b0;
    idle_all();
    repeat (3) @(negedge clk);
    check("rst_a_readdata", a_readdata, 32'h0);
    check("rst_b_readdata", b_readdata, 32'h0);
    check("rst_irqs", {30'b0, a_irq, b_irq}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset status on both ports
    expect_reg(1'b0, STATUS, 32'h100, "a_status_reset");
    expect_reg(1'b1, STATUS, 32'h100, "b_status_reset");
    check("irq_after_reset", {30'b0, a_irq, b_irq}, 32'h0);

    // Single message A -> B with B RX interrupt enabled
    wr_reg(1'b1, IEN, 32'h1);
    wr_reg(1'b0, DATA, 32'hDEADBEEF);
    check("b_irq_on_arrival", {31'b0, b_irq}, 32'h1);
    check("a_irq_quiet", {31'b0, a_irq}, 32'h0);
    expect_reg(1'b1, STATUS, 32'h1, "b_status_one");
    expect_reg(1'b1, IPEND, 32'h1, "b_pend_rx");
    expect_reg(1'b1, DATA, 32'hDEADBEEF, "b_data_pop");
    expect_reg(1'b1, STATUS, 32'h100, "b_status_drained");
    wr_reg(1'b1, IPEND, 32'h1);
    check("b_irq_w1c", {31'b0, b_irq}, 32'h0);

    // Fill A2B, then overflow
    for (int i = 0; i < 16; i++) begin
      wr_reg(1'b0, DATA, 32'h100 + i);
      exp_q.push_back(32'h100 + i);
    end
    expect_reg(1'b0, STATUS, 32'h300, "a_status_full");
    expect_reg(1'b1, STATUS, 32'h10, "b_status_16");
    wr_reg(1'b0, DATA, 32'h0BAD);
    expect_reg(1'b0, STATUS, 32'h700, "a_status_overflow");
    expect_reg(1'b1, STATUS, 32'h10, "b_status_after_drop");
    rd_reg(1'b1, DATA, rdv);
    check("b_pop_first", rdv, exp_q.pop_front());
    expect_reg(1'b0, IPEND, 32'h2, "a_pend_tx_space");
    expect_reg(1'b0, STATUS, 32'h500, "a_status_not_full");
    wr_reg(1'b0, STATUS, 32'h400);
    expect_reg(1'b0, STATUS, 32'h100, "a_overflow_w1c");
    wr_reg(1'b0, IPEND, 32'h3);
    expect_reg(1'b0, IPEND, 32'h0, "a_pend_cleared");

    // Refill to full, then simultaneous push (A) and pop (B)
    wr_reg(1'b0, DATA, 32'h110);
    exp_q.push_back(32'h110);
    expect_reg(1'b0, STATUS, 32'h300, "a_full_again");
    drive(1'b0, 1'b1, 1'b0, DATA, 32'hCAFE);
    drive(1'b1, 1'b0, 1'b1, DATA, 32'h0);
    @(negedge clk);
    idle_all();
    check("b_pop_concurrent", b_readdata, exp_q.pop_front());
    exp_q.push_back(32'hCAFE);
    expect_reg(1'b1, STATUS, 32'h10, "b_count_stays_16");
    expect_reg(1'b0, STATUS, 32'h300, "a_full_no_overflow");
    expect_reg(1'b0, IPEND, 32'h0, "a_no_tx_space_when_still_full");

    // Drain and compare order
    for (int i = 0; i < 16; i++) begin
      rd_reg(1'b1, DATA, rdv);
      check($sformatf("drain_%0d", i), rdv, exp_q.pop_front());
    end

    // Underflow and its W1C
    expect_reg(1'b1, DATA, 32'h0, "b_read_empty");
    expect_reg(1'b1, STATUS, 32'h900, "b_underflow_set");
    wr_reg(1'b1, STATUS, 32'h800);
    expect_reg(1'b1, STATUS, 32'h100, "b_underflow_w1c");

    // Push and pop together on an empty FIFO: push kept, pop underflows
    drive(1'b0, 1'b1, 1'b0, DATA, 32'h55);
    drive(1'b1, 1'b0, 1'b1, DATA, 32'h0);
    @(negedge clk);
    idle_all();
    check("b_pop_empty_concurrent", b_readdata, 32'h0);
    expect_reg(1'b1, STATUS, 32'h801, "b_status_push_kept");
    expect_reg(1'b1, DATA, 32'h55, "b_pop_55");
    wr_reg(1'b1, STATUS, 32'hFFFF_FFFF);
    expect_reg(1'b1, STATUS, 32'h100, "b_status_ro_bits");

    // A-side interrupt and deassert via IRQ_EN clear
    wr_reg(1'b0, IEN, 32'h3);
    wr_reg(1'b1, DATA, 32'h77);
    check("a_irq_on_arrival", {31'b0, a_irq}, 32'h1);
    wr_reg(1'b0, IEN, 32'h0);
    check("a_irq_en_clear", {31'b0, a_irq}, 32'h0);
    expect_reg(1'b0, IEN, 32'h0, "a_ien_readback");

    // Mid-stream reset with queued traffic
    for (int i = 0; i < 5; i++) wr_reg(1'b0, DATA, 32'h200 + i);
    wr_reg(1'b1, IEN, 32'h1);
    check("b_irq_before_reset", {31'b0, b_irq}, 32'h1);
    expect_reg(1'b1, STATUS, 32'h5, "b_status_5_queued");
    #3 reset_n = 1'b0;
    #1;
    check("async_rst_b_irq", {31'b0, b_irq}, 32'h0);
    check("async_rst_b_readdata", b_readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    expect_reg(1'b0, STATUS, 32'h100, "a_status_post_reset");
    expect_reg(1'b1, STATUS, 32'h100, "b_status_post_reset");
    expect_reg(1'b1, IEN, 32'h0, "b_ien_post_reset");
    expect_reg(1'b0, IPEND, 32'h0, "a_pend_post_reset");
    expect_reg(1'b1, IPEND, 32'h0, "b_pend_post_reset");
    expect_reg(1'b0, DATA, 32'h0, "a_data_post_reset");
    check("irq_post_reset", {30'b0, a_irq, b_irq}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
